// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier / dot-product accumulator path.
package booth_pkg;

  localparam int unsigned PROD_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 16;

  typedef enum logic [0:0] {
    ST_ACCUM,
    ST_HOLD
  } state_e;

  // Largest positive two's-complement value of a w-bit signed number.
  function automatic logic [63:0] sat_max(int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Saturating signed adder: acc + addend, clamped to the ACC_W signed range.
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam logic [63:0]      MAX64   = sat_max(ACC_W);
  localparam logic [ACC_W-1:0] SAT_MAX = MAX64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [ACC_W-1:0] raw;

  assign raw = acc + addend;

  // Overflow only when both operands share a sign and the result sign differs.
  assign ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
  assign sum = ovf ? (acc[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;

endmodule

// File: rtl/booth_dot_accumulator.sv
// Sums groups of LEN signed products with per-add saturation and presents each
// dot-product result on a valid/ready output port.
module booth_dot_accumulator
  import booth_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf
);

  localparam int unsigned      CNT_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_next, addend, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q, add_ovf, sum_ovf_q;
  logic             accept, last_accept;

  assign addend      = ACC_W'($signed(in_prod));
  assign accept      = in_valid & in_ready & ~clr;
  assign last_accept = accept & (cnt_q == LAST);

  booth_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc    (acc_q),
    .addend (addend),
    .sum    (acc_next),
    .ovf    (add_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: if (last_accept) state_d = ST_HOLD;
        ST_HOLD:  if (out_ready)   state_d = ST_ACCUM;
        default:                   state_d = ST_ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
    end else if (clr) begin
      // Abort drops both the partial group and any held result.
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
    end else if (last_accept) begin
      sum_q     <= acc_next;
      sum_ovf_q <= ovf_q | add_ovf;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q + 1'b1;
      ovf_q <= ovf_q | add_ovf;
    end
  end

  assign out_sum = sum_q;
  assign out_ovf = sum_ovf_q;

endmodule
